// File: rtl/ci_initiator_pkg.sv
// Shared widths, the "no instruction" id and the state encoding for the CI initiator.
package ci_initiator_pkg;

    localparam int CI_WIDTH    = 32;
    localparam int CI_ID_WIDTH = 8;

    localparam logic [CI_ID_WIDTH-1:0] CI_ID_NONE = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } ci_state_e;

endpackage

// File: rtl/ci_initiator_if.sv
// Custom-instruction bus between an initiator (master) and a responder (slave).
interface ci_initiator_if;
    import ci_initiator_pkg::*;

    logic                   ciStart;
    logic [CI_ID_WIDTH-1:0] ciCiN;
    logic [CI_WIDTH-1:0]    ciValueA;
    logic [CI_WIDTH-1:0]    ciValueB;
    logic                   ciDone;
    logic [CI_WIDTH-1:0]    ciResult;

    modport master (
        output ciStart, ciCiN, ciValueA, ciValueB,
        input  ciDone, ciResult
    );

    modport slave (
        input  ciStart, ciCiN, ciValueA, ciValueB,
        output ciDone, ciResult
    );

endinterface

// File: rtl/ci_watchdog.sv
// Down-counter that flags a CI transaction as expired timeoutCycles cycles after issue.
module ci_watchdog #(
    parameter int timeoutCycles = 255
) (
    input  logic clock,
    input  logic nReset,
    input  logic load,
    input  logic enable,
    output logic expired
);
    localparam int CountWidth = $clog2(timeoutCycles + 1);
    // The issue cycle itself is the first counted cycle, so reload one short.
    localparam logic [CountWidth-1:0] Reload = CountWidth'(timeoutCycles - 1);

    logic [CountWidth-1:0] count_q;
    logic [CountWidth-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = Reload;
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - CountWidth'(1);
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/ci_initiator.sv
// CI initiator: issues one request at a time to a CI responder and returns the result.
// Optional watchdog abort is built when CI_INITIATOR_TIMEOUT_EN is defined.
module ci_initiator
    import ci_initiator_pkg::*;
#(
    parameter int timeoutCycles = 255
) (
    input  logic                   clock,
    input  logic                   nReset,
    input  logic                   reqValid,
    output logic                   reqReady,
    input  logic [CI_ID_WIDTH-1:0] reqCiN,
    input  logic [CI_WIDTH-1:0]    reqValueA,
    input  logic [CI_WIDTH-1:0]    reqValueB,
    output logic                   rspValid,
    input  logic                   rspReady,
    output logic [CI_WIDTH-1:0]    rspResult,
    output logic                   rspTimeout,
    output logic                   busy,
    ci_initiator_if.master         ci
);
    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] ISSUE = ST_ISSUE;
    localparam logic [1:0] WAIT  = ST_WAIT;
    localparam logic [1:0] RESP  = ST_RESP;

    if (timeoutCycles < 1) begin : g_bad_timeout
        $error("ci_initiator: timeoutCycles must be at least 1");
    end

    logic [1:0]             state_q,       state_d;
    logic                   start_q,       start_d;
    logic [CI_ID_WIDTH-1:0] ci_n_q,        ci_n_d;
    logic [CI_WIDTH-1:0]    value_a_q,     value_a_d;
    logic [CI_WIDTH-1:0]    value_b_q,     value_b_d;
    logic                   rsp_valid_q,   rsp_valid_d;
    logic [CI_WIDTH-1:0]    rsp_result_q,  rsp_result_d;
    logic                   rsp_timeout_q, rsp_timeout_d;
    logic                   busy_q,        busy_d;
    logic                   wd_expired;

`ifdef CI_INITIATOR_TIMEOUT_EN
    logic wd_load;
    logic wd_enable;

    assign wd_load   = (state_q == IDLE) && reqValid;
    assign wd_enable = (state_q == ISSUE) || (state_q == WAIT);

    ci_watchdog #(
        .timeoutCycles(timeoutCycles)
    ) u_watchdog (
        .clock  (clock),
        .nReset (nReset),
        .load   (wd_load),
        .enable (wd_enable),
        .expired(wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    // CI id/operands are loaded straight into the output flops so they are nonzero only in ISSUE.
    always_comb begin
        state_d       = state_q;
        start_d       = 1'b0;
        ci_n_d        = CI_ID_NONE;
        value_a_d     = '0;
        value_b_d     = '0;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_timeout_d = rsp_timeout_q;
        busy_d        = busy_q;
        case (state_q)
            IDLE: begin
                if (reqValid) begin
                    state_d   = ISSUE;
                    start_d   = 1'b1;
                    ci_n_d    = reqCiN;
                    value_a_d = reqValueA;
                    value_b_d = reqValueB;
                    busy_d    = 1'b1;
                end
            end
            ISSUE, WAIT: begin
                // A done arriving in the expiry cycle still wins over the watchdog.
                if (ci.ciDone) begin
                    state_d       = RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_result_d  = ci.ciResult;
                    rsp_timeout_d = 1'b0;
                end else if (wd_expired) begin
                    state_d       = RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_result_d  = '0;
                    rsp_timeout_d = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                if (rspReady) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q       <= IDLE;
            start_q       <= 1'b0;
            ci_n_q        <= CI_ID_NONE;
            value_a_q     <= '0;
            value_b_q     <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            ci_n_q        <= ci_n_d;
            value_a_q     <= value_a_d;
            value_b_q     <= value_b_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= busy_d;
        end
    end

    assign reqReady    = (state_q == IDLE);
    assign rspValid    = rsp_valid_q;
    assign rspResult   = rsp_result_q;
    assign rspTimeout  = rsp_timeout_q;
    assign busy        = busy_q;
    assign ci.ciStart  = start_q;
    assign ci.ciCiN    = ci_n_q;
    assign ci.ciValueA = value_a_q;
    assign ci.ciValueB = value_b_q;

endmodule

// File: tb/tb_ci_initiator.sv
// Scoreboard bench for ci_initiator with a behavioural CI responder (zero-wait or k-cycle delay).
// Watchdog scenarios run only when CI_INITIATOR_TIMEOUT_EN is defined.
module tb_ci_initiator;
    import ci_initiator_pkg::*;

    typedef struct {
        logic [31:0] result;
        logic        timeout;
    } exp_t;

    logic        clock = 1'b0;
    logic        nReset;
    logic        reqValid;
    logic        reqReady;
    logic [7:0]  reqCiN;
    logic [31:0] reqValueA;
    logic [31:0] reqValueB;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspResult;
    logic        rspTimeout;
    logic        busy;

    logic        zeroWait;
    logic        strayDone;
    logic        doneDly = 1'b0;
    logic [31:0] respValue;
    int          respDelay;
    int          cnt = 0;

    int   checks   = 0;
    int   failures = 0;
    int   n;
    exp_t expQ[$];
    exp_t monExp;

    ci_initiator_if ifc();

    ci_initiator #(
        .timeoutCycles(8)
    ) dut (
        .clock     (clock),
        .nReset    (nReset),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .reqCiN    (reqCiN),
        .reqValueA (reqValueA),
        .reqValueB (reqValueB),
        .rspValid  (rspValid),
        .rspReady  (rspReady),
        .rspResult (rspResult),
        .rspTimeout(rspTimeout),
        .busy      (busy),
        .ci        (ifc)
    );

    always #5 clock = ~clock;

    // Zero-wait mode answers combinationally with A*B; delayed mode pulses done respDelay cycles after start.
    assign ifc.ciDone   = (zeroWait && ifc.ciStart) || doneDly || strayDone;
    assign ifc.ciResult = zeroWait ? (ifc.ciValueA * ifc.ciValueB) : respValue;

    always @(negedge clock) begin
        doneDly <= 1'b0;
        if (!nReset) begin
            cnt <= 0;
        end else if (ifc.ciStart && !zeroWait) begin
            cnt <= respDelay;
        end else if (cnt > 0) begin
            cnt     <= cnt - 1;
            doneDly <= (cnt == 1);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] id, input logic [31:0] a, input logic [31:0] b,
                                 input bit expectRsp, input logic [31:0] expResult, input logic expTimeout);
        exp_t e;
        reqValid  = 1'b1;
        reqCiN    = id;
        reqValueA = a;
        reqValueB = b;
        checkOutput("req_ready_idle", reqReady, 32'd1);
        if (expectRsp) begin
            e.result  = expResult;
            e.timeout = expTimeout;
            expQ.push_back(e);
        end
        @(posedge clock);
        #1;
        reqValid = 1'b0;
    endtask

    task automatic waitRsp(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clock);
            cycles = i;
            if (rspValid) break;
        end
        if (!rspValid) begin
            cycles = 99;
            $display("[TB] FAIL rsp_wait: no rspValid within 64 cycles at %0t", $time);
        end
    endtask

    always @(negedge clock) begin
        if (nReset && rspValid && rspReady) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL rsp_unexpected: got result 0x%08h, expected no response", rspResult);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("rsp_result", rspResult, monExp.result);
                checkOutput("rsp_timeout", {31'd0, rspTimeout}, {31'd0, monExp.timeout});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] aborted");
    end

    initial begin
        nReset    = 1'b0;
        reqValid  = 1'b0;
        reqCiN    = 8'h00;
        reqValueA = '0;
        reqValueB = '0;
        rspReady  = 1'b1;
        zeroWait  = 1'b1;
        strayDone = 1'b0;
        respValue = '0;
        respDelay = 0;

        repeat (2) @(negedge clock);
        checkOutput("reset_req_ready", {31'd0, reqReady}, 32'd1);
        checkOutput("reset_rsp_valid", {31'd0, rspValid}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_ci_start", {31'd0, ifc.ciStart}, 32'd0);
        checkOutput("reset_ci_id", {24'd0, ifc.ciCiN}, 32'd0);
        checkOutput("reset_rsp_result", rspResult, 32'd0);
        nReset = 1'b1;
        @(negedge clock);

        // Zero-wait responder: 0x55 * 2
        applyStimulus(8'h18, 32'h55, 32'h2, 1'b1, 32'h000000AA, 1'b0);
        @(negedge clock);
        checkOutput("t1_start", {31'd0, ifc.ciStart}, 32'd1);
        checkOutput("t1_ci_id", {24'd0, ifc.ciCiN}, 32'h18);
        checkOutput("t1_value_a", ifc.ciValueA, 32'h55);
        checkOutput("t1_value_b", ifc.ciValueB, 32'h2);
        checkOutput("t1_rsp_early", {31'd0, rspValid}, 32'd0);
        checkOutput("t1_busy", {31'd0, busy}, 32'd1);
        @(negedge clock);
        checkOutput("t1_rsp_valid", {31'd0, rspValid}, 32'd1);
        checkOutput("t1_start_drop", {31'd0, ifc.ciStart}, 32'd0);
        checkOutput("t1_ci_id_clear", {24'd0, ifc.ciCiN}, 32'd0);
        @(negedge clock);
        checkOutput("t1_req_ready_back", {31'd0, reqReady}, 32'd1);
        checkOutput("t1_busy_clear", {31'd0, busy}, 32'd0);

        // Responder with done 5 cycles after start
        zeroWait  = 1'b0;
        respDelay = 5;
        respValue = 32'hDEADBEEF;
        applyStimulus(8'h42, 32'h1111, 32'h2222, 1'b1, 32'hDEADBEEF, 1'b0);
        @(negedge clock);
        checkOutput("t2_start", {31'd0, ifc.ciStart}, 32'd1);
        checkOutput("t2_ci_id", {24'd0, ifc.ciCiN}, 32'h42);
        for (int j = 2; j <= 6; j++) begin
            @(negedge clock);
            checkOutput("t2_wait_id", {24'd0, ifc.ciCiN}, 32'd0);
            checkOutput("t2_wait_a", ifc.ciValueA, 32'd0);
            checkOutput("t2_wait_b", ifc.ciValueB, 32'd0);
            checkOutput("t2_wait_start", {31'd0, ifc.ciStart}, 32'd0);
            checkOutput("t2_wait_rsp", {31'd0, rspValid}, 32'd0);
        end
        @(negedge clock);
        checkOutput("t2_rsp_valid", {31'd0, rspValid}, 32'd1);
        @(negedge clock);

        // Response back-pressure with a second request waiting
        zeroWait = 1'b1;
        rspReady = 1'b0;
        applyStimulus(8'h03, 32'd7, 32'd6, 1'b1, 32'h0000002A, 1'b0);
        reqValid  = 1'b1;
        reqCiN    = 8'h04;
        reqValueA = 32'd3;
        reqValueB = 32'd5;
        monExp.result  = 32'h0000000F;
        monExp.timeout = 1'b0;
        expQ.push_back(monExp);
        @(negedge clock);
        checkOutput("t3_start", {31'd0, ifc.ciStart}, 32'd1);
        checkOutput("t3_ci_id", {24'd0, ifc.ciCiN}, 32'h03);
        checkOutput("t3_req_ready_issue", {31'd0, reqReady}, 32'd0);
        for (int j = 2; j <= 5; j++) begin
            @(negedge clock);
            checkOutput("t3_stall_valid", {31'd0, rspValid}, 32'd1);
            checkOutput("t3_stall_req_ready", {31'd0, reqReady}, 32'd0);
            checkOutput("t3_stall_result", rspResult, 32'h0000002A);
            checkOutput("t3_stall_start", {31'd0, ifc.ciStart}, 32'd0);
        end
        @(posedge clock);
        #1;
        rspReady = 1'b1;
        @(negedge clock);
        checkOutput("t3_consume_req_ready", {31'd0, reqReady}, 32'd0);
        @(negedge clock);
        checkOutput("t3_req_ready_back", {31'd0, reqReady}, 32'd1);
        checkOutput("t3_no_early_start", {31'd0, ifc.ciStart}, 32'd0);
        @(posedge clock);
        #1;
        reqValid = 1'b0;
        @(negedge clock);
        checkOutput("t3_second_start", {31'd0, ifc.ciStart}, 32'd1);
        checkOutput("t3_second_id", {24'd0, ifc.ciCiN}, 32'h04);
        @(negedge clock);
        checkOutput("t3_second_valid", {31'd0, rspValid}, 32'd1);
        @(negedge clock);

        // Stray done while idle
        zeroWait  = 1'b0;
        respValue = 32'h99999999;
        strayDone = 1'b1;
        @(posedge clock);
        #1;
        strayDone = 1'b0;
        @(negedge clock);
        checkOutput("t4_idle_valid", {31'd0, rspValid}, 32'd0);
        checkOutput("t4_idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("t4_idle_result", rspResult, 32'h0000000F);

        // Stray done while a response is held
        rspReady  = 1'b0;
        respDelay = 2;
        respValue = 32'h12345678;
        applyStimulus(8'h05, 32'd1, 32'd1, 1'b1, 32'h12345678, 1'b0);
        waitRsp(n);
        checkOutput("t4_latency_k2", n, 32'd4);
        respValue = 32'hCAFEF00D;
        strayDone = 1'b1;
        @(posedge clock);
        #1;
        strayDone = 1'b0;
        @(negedge clock);
        checkOutput("t4_resp_valid", {31'd0, rspValid}, 32'd1);
        checkOutput("t4_resp_result", rspResult, 32'h12345678);
        checkOutput("t4_resp_busy", {31'd0, busy}, 32'd1);
        @(posedge clock);
        #1;
        rspReady = 1'b1;
        @(negedge clock);
        @(negedge clock);
        checkOutput("t4_req_ready_back", {31'd0, reqReady}, 32'd1);

`ifdef CI_INITIATOR_TIMEOUT_EN
        // Watchdog: responder never answers
        respDelay = 0;
        applyStimulus(8'h07, 32'd5, 32'd5, 1'b1, 32'd0, 1'b1);
        waitRsp(n);
        checkOutput("t5_timeout_latency", n, 32'd9);
        checkOutput("t5_timeout_flag", {31'd0, rspTimeout}, 32'd1);
        checkOutput("t5_timeout_result", rspResult, 32'd0);
        @(negedge clock);

        // Watchdog: done lands exactly on expiry
        respDelay = 7;
        respValue = 32'h0BADF00D;
        applyStimulus(8'h08, 32'd5, 32'd5, 1'b1, 32'h0BADF00D, 1'b0);
        waitRsp(n);
        checkOutput("t5_expiry_latency", n, 32'd9);
        checkOutput("t5_expiry_flag", {31'd0, rspTimeout}, 32'd0);
        @(negedge clock);
`endif

        // Reset while waiting on a silent responder
        respDelay = 0;
        applyStimulus(8'h09, 32'd1, 32'd2, 1'b0, 32'd0, 1'b0);
        @(negedge clock);
        @(negedge clock);
        checkOutput("t6_wait_busy", {31'd0, busy}, 32'd1);
        #2;
        nReset = 1'b0;
        #1;
        checkOutput("t6_rst_req_ready", {31'd0, reqReady}, 32'd1);
        checkOutput("t6_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("t6_rst_valid", {31'd0, rspValid}, 32'd0);
        checkOutput("t6_rst_start", {31'd0, ifc.ciStart}, 32'd0);
        checkOutput("t6_rst_result", rspResult, 32'd0);
        checkOutput("t6_rst_timeout", {31'd0, rspTimeout}, 32'd0);
        repeat (2) @(negedge clock);
        nReset = 1'b1;
        @(negedge clock);
        checkOutput("t6_post_valid", {31'd0, rspValid}, 32'd0);
        zeroWait = 1'b1;
        applyStimulus(8'h21, 32'h10, 32'h10, 1'b1, 32'h00000100, 1'b0);
        waitRsp(n);
        checkOutput("t6_post_latency", n, 32'd2);

        repeat (3) @(negedge clock);
        checkOutput("scoreboard_drain", expQ.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ci_initiator.md
# ci_initiator

Initiator side of the custom-instruction (CI) interface: accepts one CI request at a time from an internal requester (test harness, DMA-side sequencer or accelerator controller) and issues it to any CI responder such as the Sobel multiplier. It drives the `start`/`ciN`/`valueA`/`valueB` pulse, waits for `done`, captures `result`, and returns it over a valid/ready response port. An optional watchdog aborts transactions whose responder never asserts `done`.

## Interface
- `timeoutCycles`, 255: cycles to wait for `done` after `start` before aborting; must be at least 1; only used with the watchdog.
- `clock`  in  1  sole clock; all logic is rising-edge.
- `nReset`  in  1  asynchronous, active-low reset.
- `reqValid`  in  1  request present.
- `reqReady`  out  1  initiator can accept a request.
- `reqCiN`  in  8  custom-instruction id to issue.
- `reqValueA`, `reqValueB`  in  32 each  operands.
- `rspValid`  out  1  response available.
- `rspReady`  in  1  requester consumes the response.
- `rspResult`  out  32  captured `ciResult`; 0 on timeout.
- `rspTimeout`  out  1  response was produced by the watchdog.
- `busy`  out  1  high from request acceptance until the response is consumed.
- `ciStart`  out  1  CI start pulse.
- `ciCiN`  out  8  CI id.
- `ciValueA`, `ciValueB`  out  32 each  CI operands.
- `ciDone`  in  1  responder completion.
- `ciResult`  in  32  responder result; sampled only while `ciDone` is high.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `reqReady`=1.
  - When `reqValid` is high, latch id and operands and go to ISSUE.
- ISSUE:
  - Lasts exactly one cycle.
  - `ciStart`=1, and `ciCiN`/`ciValueA`/`ciValueB` carry the latched values.
  - If `ciDone`=1 in the same cycle (combinational responder), capture `ciResult` and go to RESP; otherwise go to WAIT.
- WAIT:
  - `ciStart`=0.
  - On `ciDone`=1, capture `ciResult` and go to RESP.
- RESP:
  - `rspValid`=1, and `rspResult`/`rspTimeout` stay stable until `rspReady`=1; then go to IDLE.
- Outside ISSUE, `ciCiN`, `ciValueA` and `ciValueB` are driven to 0. Id 0 means "no instruction".
- `ciDone` is ignored in IDLE and RESP; stray pulses have no effect.
- `busy` is 1 in every state except IDLE.
- A request with `reqCiN`=0 is still issued as-is; the initiator does not filter ids.
- Only one transaction is ever outstanding. `start` is never reasserted before `done` (or a timeout) and response consumption.
- Reset asserted mid-transaction:
  - The state returns to IDLE immediately and the captured data is discarded.
  - The responder sees `ciStart` drop; no response is produced.

## Timing
- Reset values:
  - `reqReady`=1.
  - `rspValid`, `rspTimeout`, `busy` and `ciStart` = 0.
  - `rspResult`, `ciCiN`, `ciValueA` and `ciValueB` = 0.
- All outputs are registered except `reqReady`, which is decoded from state.
- Request handshake at edge N → `ciStart` high during cycle N+1.
- Zero-wait responder (`ciDone` during the `start` cycle) → `rspValid` from cycle N+2. Minimum request-to-response latency is 2 cycles.
- Responder with k-cycle delay (`done` k cycles after `start`) → `rspValid` at N+2+k.
- `rspValid` and `rspReady` both high at edge M → `reqReady` high in cycle M+1. Maximum throughput is one transaction per 3 cycles.
- With the watchdog, in the cycle after the timeout expires: `rspValid`=1, `rspTimeout`=1, `rspResult`=0.
  - Timeout expires when `ciDone` has not been seen for `timeoutCycles` cycles counted from the ISSUE cycle.
  - If `ciDone` arrives in the same cycle as expiry, `ciDone` wins: result captured, `rspTimeout`=0.

## Configuration
- Macro: `CI_INITIATOR_TIMEOUT_EN`.
- Defined:
  - A watchdog counter runs from ISSUE through WAIT, reloads on every new issue, and implements the abort described under Timing.
- Undefined:
  - No counter is built and WAIT lasts until `ciDone`, indefinitely if necessary.
  - `rspTimeout` is tied to 0 and `timeoutCycles` is unused.

## Structure
- Package `ci_initiator_pkg`:
  - State enum (IDLE, ISSUE, WAIT, RESP).
  - `CI_ID_NONE`=8'h00, `CI_WIDTH`=32, `CI_ID_WIDTH`=8.
- Sub-module `ci_watchdog`:
  - Ports: load, enable, expired.
  - Counter width is `$clog2(timeoutCycles+1)`.
  - Instantiated only under `CI_INITIATOR_TIMEOUT_EN`.

## Test plan
- Zero-wait responder with id 0x18, id 0x18, `valueA`=0x00000055, `valueB`=2 → one `ciStart` pulse with `ciCiN`=0x18; `rspValid` 2 cycles after acceptance; `rspResult`=0x000000AA, `rspTimeout`=0.
- Responder with `done` 5 cycles after `start`, `ciResult`=0xDEADBEEF → `rspValid` at acceptance+7 with 0xDEADBEEF; `ciCiN` and operands are 0 during WAIT.
- Hold `rspReady` low 4 cycles, with `reqValid` held high carrying a second request → `reqReady` stays 0, `rspResult` stays stable, and no second `ciStart` until the cycle after consumption.
- Stray `ciDone` pulses in IDLE and RESP → no state change and no response change.
- Watchdog (macro defined, `timeoutCycles`=8) against a responder that never asserts `done` → `rspValid`=1, `rspTimeout`=1, `rspResult`=0 after the timeout. Repeat with `ciDone` arriving exactly at expiry → `rspTimeout`=0 and the result is captured.
- `nReset` low during WAIT → all outputs take reset values asynchronously; after release, a new request completes normally.
